// File: rtl/sys_array_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sys_array_pkg
//  Description : Shared constants and helpers for the weight-stationary
//                systolic array processing element: default operand and
//                accumulator widths, operand extension fill and saturation
//                limit helpers.
//  Config      : SYS_ARRAY_SATURATE_EN (used by sys_array_mac)
//  Revision    : 1.0 - initial release
// ============================================================================
package sys_array_pkg;

    localparam int c_DATA_WIDTH_DEF = 8;
    localparam int c_ACC_WIDTH_DEF  = 2 * c_DATA_WIDTH_DEF;

    // Fill bit used when widening a value: replicated MSB when the operand is
    // two's-complement, zero otherwise.
    function automatic logic ext_fill(input logic msb, input logic is_signed);
        return is_signed & msb;
    endfunction

    // MSB of the saturation ceiling; all lower bits of the ceiling are 1.
    // Signed ceiling is 0111..1, unsigned ceiling is 1111..1.
    function automatic logic sat_max_msb(input logic is_signed);
        return ~is_signed;
    endfunction

    // MSB of the saturation floor; all lower bits of the floor are 0.
    // Signed floor is 1000..0, unsigned floor is 0000..0.
    function automatic logic sat_min_msb(input logic is_signed);
        return is_signed;
    endfunction

endpackage : sys_array_pkg
`default_nettype wire

// File: rtl/sys_array_mac.sv
`default_nettype none
// ============================================================================
//  Module      : sys_array_mac
//  Description : Combinational multiply-accumulate for one array cell.
//                Product is 2*DATA_WIDTH wide, extended to ACC_WIDTH in the
//                selected signedness, then added to the incoming partial sum.
//  Config      : SYS_ARRAY_SATURATE_EN - clamp the sum instead of wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_array_mac
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = c_ACC_WIDTH_DEF
) (
    input  logic                  i_signed_mode,
    input  logic [DATA_WIDTH-1:0] i_act,
    input  logic [DATA_WIDTH-1:0] i_weight,
    input  logic [ACC_WIDTH-1:0]  i_psum,
    output logic [ACC_WIDTH-1:0]  o_psum
);

    localparam int c_PROD_W = 2 * DATA_WIDTH;

    logic [c_PROD_W-1:0]  w_act_ext;
    logic [c_PROD_W-1:0]  w_wgt_ext;
    logic [c_PROD_W-1:0]  w_prod;
    logic [ACC_WIDTH-1:0] w_prod_ext;

    // One multiplier serves both modes: operands are widened to the product
    // width in the requested signedness, so the low 2*DATA_WIDTH bits of the
    // product are correct for either interpretation.
    always_comb begin
        w_act_ext = {{DATA_WIDTH{ext_fill(i_act[DATA_WIDTH-1], i_signed_mode)}}, i_act};
        w_wgt_ext = {{DATA_WIDTH{ext_fill(i_weight[DATA_WIDTH-1], i_signed_mode)}}, i_weight};
        w_prod    = w_act_ext * w_wgt_ext;
    end

    generate
        if (ACC_WIDTH > c_PROD_W) begin : g_prod_ext
            assign w_prod_ext = {{(ACC_WIDTH - c_PROD_W){ext_fill(w_prod[c_PROD_W-1], i_signed_mode)}},
                                 w_prod};
        end else begin : g_prod_noext
            assign w_prod_ext = w_prod;
        end
    endgenerate

`ifdef SYS_ARRAY_SATURATE_EN
    logic [ACC_WIDTH:0] w_sum_full;
    logic               w_ovf;
    logic               w_neg;

    // Add at ACC_WIDTH+1 bits so overflow is visible, then clamp toward the
    // side the true result fell on.
    always_comb begin
        w_sum_full = {ext_fill(w_prod_ext[ACC_WIDTH-1], i_signed_mode), w_prod_ext}
                   + {ext_fill(i_psum[ACC_WIDTH-1], i_signed_mode), i_psum};
        if (i_signed_mode) begin
            w_ovf = w_sum_full[ACC_WIDTH] ^ w_sum_full[ACC_WIDTH-1];
        end else begin
            w_ovf = w_sum_full[ACC_WIDTH];
        end
        w_neg = i_signed_mode & w_sum_full[ACC_WIDTH];
        if (!w_ovf) begin
            o_psum = w_sum_full[ACC_WIDTH-1:0];
        end else if (w_neg) begin
            o_psum = {sat_min_msb(i_signed_mode), {(ACC_WIDTH-1){1'b0}}};
        end else begin
            o_psum = {sat_max_msb(i_signed_mode), {(ACC_WIDTH-1){1'b1}}};
        end
    end
`else
    // Modulo-2^ACC_WIDTH sum; signedness only matters for the extension.
    assign o_psum = w_prod_ext + i_psum;
`endif

endmodule : sys_array_mac
`default_nettype wire

// File: rtl/sys_array_pe.sv
`default_nettype none
// ============================================================================
//  Module      : sys_array_pe
//  Description : Weight-stationary systolic array processing element with a
//                double-buffered weight (shadow loaded via a column daisy
//                chain, swapped into the active register), runtime
//                signed/unsigned MAC, valid tracking and parametrised
//                accumulator width. Compute latency is one cycle.
//  Config      : SYS_ARRAY_SATURATE_EN - saturating accumulate (in sys_array_mac)
//  Revision    : 1.0 - initial release
// ============================================================================
module sys_array_pe
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  signed_mode,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic [ACC_WIDTH-1:0]  prop_data,
    input  logic                  weight_shift,
    input  logic [DATA_WIDTH-1:0] weight_in,
    input  logic                  weight_swap,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] prop_param,
    output logic                  prop_valid,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  shadow_valid,
    output logic                  swap_err
);

    generate
        if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_check
            $error("sys_array_pe: ACC_WIDTH must be >= 2*DATA_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_shadow_q,       w_shadow_d;
    logic                  r_shadow_valid_q, w_shadow_valid_d;
    logic [DATA_WIDTH-1:0] r_active_q,       w_active_d;
    logic [ACC_WIDTH-1:0]  r_out_data_q,     w_out_data_d;
    logic                  r_out_valid_q,    w_out_valid_d;
    logic [DATA_WIDTH-1:0] r_prop_param_q,   w_prop_param_d;
    logic                  r_prop_valid_q,   w_prop_valid_d;
    logic                  r_swap_err_q,     w_swap_err_d;
    logic                  w_swap_ok;
    logic [ACC_WIDTH-1:0]  w_mac_sum;

    // The MAC always sees the pre-swap active weight; a swap in the same
    // cycle only takes effect for the next operation.
    sys_array_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .i_signed_mode (signed_mode),
        .i_act         (input_data),
        .i_weight      (r_active_q),
        .i_psum        (prop_data),
        .o_psum        (w_mac_sum)
    );

    // Next-state for the weight buffers, swap error and the compute pipeline.
    always_comb begin
        w_swap_ok        = weight_swap & r_shadow_valid_q;
        w_active_d       = w_swap_ok ? r_shadow_q : r_active_q;
        w_shadow_d       = weight_shift ? weight_in : r_shadow_q;
        // A shift refills the shadow even when it is swapped out this cycle.
        w_shadow_valid_d = weight_shift ? 1'b1 : (w_swap_ok ? 1'b0 : r_shadow_valid_q);
        w_swap_err_d     = weight_swap & ~r_shadow_valid_q;
        w_out_data_d     = in_valid ? w_mac_sum  : r_out_data_q;
        w_prop_param_d   = in_valid ? input_data : r_prop_param_q;
        w_out_valid_d    = in_valid;
        w_prop_valid_d   = in_valid;
    end

    // State registers; reset discards weights and in-flight data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shadow_q       <= '0;
            r_shadow_valid_q <= 1'b0;
            r_active_q       <= '0;
            r_out_data_q     <= '0;
            r_out_valid_q    <= 1'b0;
            r_prop_param_q   <= '0;
            r_prop_valid_q   <= 1'b0;
            r_swap_err_q     <= 1'b0;
        end else begin
            r_shadow_q       <= w_shadow_d;
            r_shadow_valid_q <= w_shadow_valid_d;
            r_active_q       <= w_active_d;
            r_out_data_q     <= w_out_data_d;
            r_out_valid_q    <= w_out_valid_d;
            r_prop_param_q   <= w_prop_param_d;
            r_prop_valid_q   <= w_prop_valid_d;
            r_swap_err_q     <= w_swap_err_d;
        end
    end

    assign out_data     = r_out_data_q;
    assign out_valid    = r_out_valid_q;
    assign prop_param   = r_prop_param_q;
    assign prop_valid   = r_prop_valid_q;
    assign weight_out   = r_shadow_q;
    assign shadow_valid = r_shadow_valid_q;
    assign swap_err     = r_swap_err_q;

endmodule : sys_array_pe
`default_nettype wire

// File: doc/sys_array_pe.md
Name: sys_array_pe

Overview:
Parametrised processing element for the weight-stationary systolic array. It is the next generation of the basic array cell and adds the following:
- double-buffered weights, loaded through a daisy chain down each column;
- runtime signed/unsigned arithmetic;
- valid tracking through the array;
- a configurable accumulator width.

Tiles of these cells form the array core. Activations move right, partial sums move down, and weights shift down the column.

Parameters:
DATA_WIDTH, 8, width of activations and weights
ACC_WIDTH, 2*DATA_WIDTH, width of partial sums; must be >= 2*DATA_WIDTH (elaboration error otherwise)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
in_valid  in  1  input_data/prop_data are valid this cycle
input_data  in  DATA_WIDTH  activation from the left neighbour
prop_data  in  ACC_WIDTH  partial sum from the upper neighbour
weight_shift  in  1  shift the weight chain one cell
weight_in  in  DATA_WIDTH  weight from the upper cell's weight_out
weight_swap  in  1  copy the shadow weight into the active weight
out_data  out  ACC_WIDTH  partial sum to the lower neighbour
out_valid  out  1  out_data updated this cycle
prop_param  out  DATA_WIDTH  activation to the right neighbour
prop_valid  out  1  prop_param valid
weight_out  out  DATA_WIDTH  shadow weight, to the next cell's weight_in
shadow_valid  out  1  shadow holds a weight not yet swapped in
swap_err  out  1  one-cycle pulse: swap requested while shadow empty

Behaviour:
- Clocking and reset:
  - Single clock, synchronous active-low reset on the rising edge of clk.
  - Reset has priority over every other input.
  - Reset clears all outputs, the shadow weight and the active weight to 0.
  - Reset in mid-operation discards any loaded weights and any in-flight data.
- Weight chain:
  - When weight_shift = 1: shadow <= weight_in and shadow_valid <= 1.
  - weight_out is the shadow register itself, so one cell of chain latency per cycle.
- Swap:
  - When weight_swap = 1 and shadow_valid = 1: active <= shadow and shadow_valid <= 0.
  - When weight_swap = 1 and shadow_valid = 0: active is unchanged and swap_err pulses high for one cycle.
- Swap and shift in the same cycle:
  - active takes the old shadow.
  - shadow takes weight_in.
  - shadow_valid ends at 1.
  - No swap_err if the old shadow was valid.
- Compute (latency 1):
  - When in_valid = 1 on edge N, then at N+1:
    - out_data = prop_data + ext(input_data * active);
    - out_valid = 1;
    - prop_param = input_data;
    - prop_valid = 1.
- Arithmetic:
  - Product width is 2*DATA_WIDTH, then sign-extended (signed_mode = 1) or zero-extended (signed_mode = 0) to ACC_WIDTH.
  - prop_data is interpreted in the same signedness.
  - The default result wraps modulo 2^ACC_WIDTH.
- Compute in the same cycle as swap: the multiply uses the pre-swap active weight; the new weight applies from the next cycle.
- Weight operations do not stall compute; any mix of shift, swap and compute is legal in a single cycle.
- When in_valid = 0: out_data and prop_param hold their values; out_valid and prop_valid go to 0.
- signed_mode is sampled on the same edge as in_valid; changing it mid-stream affects only that cycle's operation.

Optional Feature:
SYS_ARRAY_SATURATE_EN
- Defined: the sum saturates instead of wrapping.
  - Signed mode: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Unsigned mode: clamp to 2^ACC_WIDTH-1.
  - Overflow is detected on the full-precision sum (ACC_WIDTH+1 bits).
- Undefined: wrap-around as specified above; no extra logic.

Decomposition:
- Package sys_array_pkg:
  - default DATA_WIDTH/ACC_WIDTH constants;
  - function for signed/unsigned extension;
  - functions for saturation max/min limits.
- Sub-module sys_array_mac: combinational multiply, extend, add and optional saturate. It is instantiated once in sys_array_pe, which keeps all registers, the weight chain and the valid logic.

Test Plan:
(All scenarios use DATA_WIDTH=8, ACC_WIDTH=16.)
1. Reset: assert reset_n=0 for 2 cycles after random activity -> all outputs 0, shadow_valid 0.
2. Basic compute:
   - stimulus: shift weight_in=3, swap, then in_valid with input 5, prop 10;
   - response: out_data=25, out_valid=1, prop_param=5, prop_valid=1 one cycle later.
3. Signedness, weight 0xFE, input 3, prop 0:
   - signed_mode=1 -> out_data=0xFFFA (-6);
   - signed_mode=0 -> out_data=0x02FA (762).
4. Swap/compute overlap:
   - stimulus: active=2, shadow=7; in_valid with input 4 in the same cycle as weight_swap, then input 4 again;
   - response: out_data 8, then 28.
5. Empty-shadow swap:
   - stimulus: swap with shadow_valid=0;
   - response: swap_err high for exactly one cycle, active unchanged (next compute uses the old weight);
   - then check simultaneous shift+swap: active gets the old shadow, shadow_valid=1.
6. Overflow, signed, prop 32767, input 1, weight 1:
   - with SYS_ARRAY_SATURATE_EN: out_data=32767;
   - without it: out_data=0x8000;
   - unsigned, prop 0xFFFF, with the macro: out_data=0xFFFF.
